alu_seq: RTL
============

# alu_seq

Parametrised, registered ALU with a valid/ready input handshake, a persistent carry flag for multi-word add/subtract chains, and a multicycle shift-add multiplier. It is the next-generation datapath ALU for the CPU core. It replaces the fixed 8-bit combinational unit and sits between the register-file read stage and writeback, which consumes `out_valid` and `result`.

## Interface
- `WIDTH`, default 8: operand and result width; legal for any value ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; transfer occurs on an edge where `in_valid && in_ready`.
- `a`, `b`  in  WIDTH  operands; sampled only at transfer.
- `op`  in  4  opcode; sampled only at transfer.
- `out_valid`  out  1  one-cycle pulse: new result and flags are valid.
- `result`  out  WIDTH  last completed result; held between completions.
- `zero`, `carry`, `negative`, `overflow`  out  1 each  flags of the last completed op; held.
- `flag_c`  out  1  stored carry flag; equals `carry` after every completion.

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~a.
  - 6 SHL: a<<1.
  - 7 SHR: logical a>>1.
  - 8 ADC: a+b+flag_c.
  - 9 SBC: a−b−flag_c.
  - 10 MUL: unsigned a×b, low WIDTH bits.
  - 11–15 reserved: result = a.
- Arithmetic is performed at WIDTH+1 bits.
- `carry` per op:
  - ADD/ADC: bit WIDTH of the sum.
  - SUB/SBC: borrow, i.e. bit WIDTH of the (WIDTH+1)-bit difference; 1 when the unsigned minuend is less than the subtrahend (plus carry-in).
  - SHL: a[WIDTH−1].
  - SHR: a[0].
  - MUL: OR of the upper WIDTH product bits.
  - All other ops: 0.
- `overflow`: signed two's-complement overflow for ADD/ADC/SUB/SBC; 0 for all other ops.
- `zero` = (result == 0). `negative` = result[WIDTH−1].
- `flag_c` is loaded with the new `carry` value on every completion, and only then.
- States:
  - IDLE: `in_ready`=1.
    - Transfer of a non-MUL op: compute and register result and flags on that edge; stay in IDLE.
    - Transfer of MUL: latch a and b, clear the accumulator, load count=WIDTH; go to MUL.
  - MUL: `in_ready`=0.
    - Each edge performs one shift-add step and decrements count.
    - On the edge that completes the last step, register result and flags and return to IDLE.
- `in_valid` while in MUL is ignored: no transfer occurs, and the presented values are not captured.
- Reset state:
  - `result`=0.
  - All flags, `flag_c` and `out_valid` = 0.
  - `in_ready`=1, state IDLE.
- Reset asserted mid-MUL aborts the operation: no `out_valid` is produced and the partial product is discarded.

## Timing
- Non-MUL ops, transfer at edge T:
  - `result`, flags and `flag_c` update at T.
  - `out_valid`=1 for the cycle after T only.
  - Latency 1; throughput 1 op/cycle; `in_ready` stays 1.
- Back-to-back chaining: an ADC/SBC transferred at T+1 uses the `flag_c` written at T. No hazard, no stall.
- MUL, transfer at edge T:
  - `in_ready`=0 in the cycles following edges T … T+WIDTH−1.
  - Result and flags are registered at edge T+WIDTH.
  - `out_valid`=1 in the cycle after T+WIDTH, and `in_ready` is 1 in that same cycle.
  - A new op may transfer at edge T+WIDTH+1 and sees the MUL's `flag_c`.
- `out_valid` is never high in two consecutive cycles unless back-to-back transfers occurred.
- Output values remain stable while no completion occurs.

## Test plan
All scenarios use WIDTH=8.
1. ADD 0xFF+0x01, then ADC 0x10+0x20 on the next cycle:
   - First result: 0x00 with zero=1, carry=1, overflow=0.
   - Second result: 0x31, carry=0.
   - `out_valid` high on two consecutive cycles.
2. ADD 0x7F+0x01 → 0x80 with negative=1, overflow=1, carry=0. Then SUB 0x05−0x06 → 0xFF with carry=1, negative=1.
3. SUB 0x05−0x06, then SBC 0x10−0x00 on the next cycle → 0x0F, carry=0, flag_c=0.
4. MUL cases:
   - MUL 0x0F×0x11 → 0xFF, carry=0. `in_ready` low for exactly 8 cycles; `out_valid` 8 cycles after the transfer edge.
   - MUL 0x10×0x10 → 0x00, zero=1, carry=1.
   - Changes to `a`, `b` or `in_valid` during the busy cycles must have no effect.
5. Shift, NOT and reserved ops:
   - SHL 0x81 → 0x02, carry=1.
   - SHR 0x81 → 0x40, carry=1.
   - NOT 0x00 → 0xFF, negative=1.
   - op=12 with a=0x80 → 0x80, negative=1, carry=0, overflow=0.
6. Start MUL 0x03×0x05, then pull `rst_n` low 3 cycles after transfer. Required response:
   - Outputs immediately 0, `in_ready`=1.
   - No `out_valid` after release.
   - A subsequent ADD 0x01+0x01 → 0x02 with latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready input handshake, a persistent
// carry flag for multi-word add/subtract chains and a multicycle
// shift-add multiplier (one partial-product step per clock).
//
// Handshake: an operation transfers on a rising edge where
// in_valid && in_ready. in_ready is high only in IDLE. A, B and OP are
// sampled only at transfer. Every completion registers result and flags
// and raises out_valid for exactly the following cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             flag_c
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBC = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t state, state_next;

  // Multiplier datapath: shifted multiplicand, shrinking multiplier,
  // running accumulator and remaining step count.
  logic [2*WIDTH-1:0] mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_step;

  // Single-cycle ALU outputs
  logic             cin;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  // Completion mux shared by the single-cycle path and the multiplier
  logic             done;
  logic [WIDTH-1:0] done_res;
  logic             done_c;
  logic             done_v;

  assign acc_step  = acc + (mul_b[0] ? mul_a : '0);
  assign last_step = (count == CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid && op == OP_MUL) state_next = S_MUL;
      S_MUL:   if (last_step) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state == S_IDLE);
  end

  // Single-cycle ALU, evaluated at WIDTH+1 bits for carry/borrow
  always_comb begin
    cin      = (op == OP_ADC || op == OP_SBC) ? flag_c : 1'b0;
    sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    alu_res  = a;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      default: alu_res = a;
    endcase
  end

  // Select what (if anything) completes on the coming edge
  always_comb begin
    done     = 1'b0;
    done_res = alu_res;
    done_c   = alu_c;
    done_v   = alu_v;
    if (state == S_MUL) begin
      done     = last_step;
      done_res = acc_step[WIDTH-1:0];
      done_c   = |acc_step[2*WIDTH-1:WIDTH];
      done_v   = 1'b0;
    end else if (in_valid && op != OP_MUL) begin
      done = 1'b1;
    end
  end

  // Multiplier operand latch and shift-add steps; reset discards partials
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      count <= '0;
    end else if (state == S_IDLE) begin
      if (in_valid && op == OP_MUL) begin
        mul_a <= {{WIDTH{1'b0}}, a};
        mul_b <= b;
        acc   <= '0;
        count <= CW'(WIDTH);
      end
    end else begin
      acc   <= acc_step;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      count <= count - CW'(1);
    end
  end

  // Result/flag registers and the one-cycle completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      flag_c    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= done;
      if (done) begin
        result   <= done_res;
        zero     <= (done_res == '0);
        carry    <= done_c;
        negative <= done_res[WIDTH-1];
        overflow <= done_v;
        flag_c   <= done_c;
      end
    end
  end

endmodule
